// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg
//   Shared encodings for the PC fetch sequencer: FSM state codes and the
//   kind of PC update (increment or load) performed in the UPDATE state.
package pc_fetch_pkg;

   typedef logic [2:0] fetch_state_t;

   localparam fetch_state_t IDLE   = 3'd0;
   localparam fetch_state_t FETCH  = 3'd1;
   localparam fetch_state_t HOLD   = 3'd2;
   localparam fetch_state_t UPDATE = 3'd3;
   localparam fetch_state_t HALTED = 3'd4;

   localparam logic UPD_INC  = 1'b0;
   localparam logic UPD_LOAD = 1'b1;

endpackage

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer
//   Drives the program counter register: fetches the instruction at PCout
//   over a req/ack memory handshake, presents it to decode over valid/ready,
//   then increments the PC or loads a captured redirect target.
//
//   Ports
//     clk, rst_n                 clock, synchronous active-low reset
//     PCout                      current PC from the PC register
//     PCdata, PCload, PCinc      PC register controls (one-cycle strobes)
//     imem_req, imem_addr        fetch request / address
//     imem_ack, imem_rdata       fetch completion / instruction data
//     instr, instr_valid         instruction to decode
//     instr_ready                decode accepts instr
//     redir_valid, redir_target  branch/jump redirect request
//     halt                       level; stop fetching at the next UPDATE
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | out of reset, decide between fetching and halting
//   FETCH  | imem_req asserted at PCout, waiting for imem_ack
//   HOLD   | instr_valid asserted, waiting for instr_ready or redirect
//   UPDATE | one-cycle PCinc or PCload strobe
//   HALTED | parked while halt=1; redirects ignored
module pc_fetch_sequencer
   import pc_fetch_pkg::*;
#(
   parameter int N = 32,
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] PCout,
   output logic [N-1:0] PCdata,
   output logic         PCload,
   output logic         PCinc,
   output logic         imem_req,
   output logic [N-1:0] imem_addr,
   input  logic         imem_ack,
   input  logic [W-1:0] imem_rdata,
   output logic [W-1:0] instr,
   output logic         instr_valid,
   input  logic         instr_ready,
   input  logic         redir_valid,
   input  logic [N-1:0] redir_target,
   input  logic         halt
);

   fetch_state_t state;
   logic         redir_pend;
   logic         upd_kind;
   logic [N-1:0] tgt_q;
   logic         capture_en;

   // Redirects are only meaningful while a fetch/update is in flight.
   assign capture_en = redir_valid &&
                       ((state == FETCH) || (state == HOLD) || (state == UPDATE));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         redir_pend <= 1'b0;
         tgt_q      <= '0;
         upd_kind   <= UPD_INC;
         instr      <= '0;
      end else begin
         // A redirect arriving during a load UPDATE wins over the clear, so
         // it is applied after the next fetch is squashed.
         if (capture_en) begin
            redir_pend <= 1'b1;
            tgt_q      <= redir_target;
         end else if ((state == UPDATE) && (upd_kind == UPD_LOAD)) begin
            redir_pend <= 1'b0;
         end

         case (state)
            IDLE: begin
               state <= halt ? HALTED : FETCH;
            end
            FETCH: begin
               if (imem_ack) begin
                  if (redir_pend || redir_valid) begin
                     upd_kind <= UPD_LOAD;
                     state    <= UPDATE;
                  end else begin
                     instr <= imem_rdata;
                     state <= HOLD;
                  end
               end
            end
            HOLD: begin
               // Redirect squashes the held instruction even if accepted now.
               if (redir_valid || redir_pend) begin
                  upd_kind <= UPD_LOAD;
                  state    <= UPDATE;
               end else if (instr_ready) begin
                  upd_kind <= UPD_INC;
                  state    <= UPDATE;
               end
            end
            UPDATE: begin
               state <= halt ? HALTED : FETCH;
            end
            HALTED: begin
               if (!halt) state <= FETCH;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign imem_req    = (state == FETCH);
   assign imem_addr   = (state == FETCH) ? PCout : '0;
   assign instr_valid = (state == HOLD);
   assign PCload      = (state == UPDATE) && (upd_kind == UPD_LOAD);
   assign PCinc       = (state == UPDATE) && (upd_kind == UPD_INC);
   assign PCdata      = PCload ? tgt_q : '0;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
module tb_pc_fetch_sequencer;

   localparam int N = 32;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [N-1:0] PCout;
   logic [N-1:0] PCdata;
   logic         PCload;
   logic         PCinc;
   logic         imem_req;
   logic [N-1:0] imem_addr;
   logic         imem_ack;
   logic [W-1:0] imem_rdata;
   logic [W-1:0] instr;
   logic         instr_valid;
   logic         instr_ready;
   logic         redir_valid;
   logic [N-1:0] redir_target;
   logic         halt;

   always #5 clk = ~clk;

   pc_fetch_sequencer #(.N(N), .W(W)) dut (
      .clk(clk), .rst_n(rst_n), .PCout(PCout), .PCdata(PCdata),
      .PCload(PCload), .PCinc(PCinc), .imem_req(imem_req),
      .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .redir_valid(redir_valid), .redir_target(redir_target), .halt(halt)
   );

   // Behavioural program_counter_nbit closing the loop.
   logic [N-1:0] pc;
   always @(posedge clk) begin
      if (!rst_n)      pc <= '0;
      else if (PCload) pc <= PCdata;
      else if (PCinc)  pc <= pc + 1'b1;
   end
   assign PCout = pc;

   // Instruction memory: acks after ack_delay wait cycles, data = addr+0x100.
   int   ack_delay;
   int   wcnt;
   logic ack_force;
   always @(posedge clk) begin
      if (!rst_n || !imem_req) wcnt <= 0;
      else if (!imem_ack)      wcnt <= wcnt + 1;
   end
   assign imem_ack   = (imem_req && (wcnt == ack_delay)) || ack_force;
   assign imem_rdata = ack_force ? 32'hDEAD_BEEF : (imem_addr + 32'h100);

   int errors = 0;
   int checks = 0;
   logic [W-1:0] exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      check("strobe_exclusive", {63'd0, PCload & PCinc}, 64'd0);
   endtask

   task automatic wait_req(output int cyc);
      cyc = 0;
      while (!imem_req && cyc < 50) begin tick(); cyc++; end
      if (!imem_req) check("timeout_req", 64'd0, 64'd1);
   endtask

   task automatic wait_valid(output int cyc);
      cyc = 0;
      while (!instr_valid && cyc < 50) begin tick(); cyc++; end
      if (!instr_valid) check("timeout_valid", 64'd0, 64'd1);
   endtask

   // Accept the held instruction: compare against the scoreboard, pulse ready.
   task automatic accept(input string name);
      logic [W-1:0] e;
      if (exp_q.size() == 0) begin
         check({name, "_sb_empty"}, 64'd1, 64'd0);
         e = '0;
      end else e = exp_q.pop_front();
      check({name, "_instr"}, instr, e);
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      check({name, "_pcinc"}, PCinc, 1'b1);
      check({name, "_valid_drop"}, instr_valid, 1'b0);
   endtask

   task automatic check_idle_outputs(input string name);
      check({name, "_req"}, imem_req, 1'b0);
      check({name, "_addr"}, imem_addr, '0);
      check({name, "_valid"}, instr_valid, 1'b0);
      check({name, "_pcload"}, PCload, 1'b0);
      check({name, "_pcinc"}, PCinc, 1'b0);
      check({name, "_pcdata"}, PCdata, '0);
      check({name, "_instr"}, instr, '0);
   endtask

   typedef struct {
      int           delay;
      int           ready_wait;
      logic [N-1:0] exp_addr;
      logic [W-1:0] exp_instr;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int c;
      vecs[0] = '{0, 0, 32'd0, 32'h100};
      vecs[1] = '{0, 0, 32'd1, 32'h101};
      vecs[2] = '{0, 0, 32'd2, 32'h102};
      vecs[3] = '{0, 5, 32'd3, 32'h103};
      vecs[4] = '{2, 0, 32'd4, 32'h104};
      vecs[5] = '{1, 3, 32'd5, 32'h105};

      rst_n = 1'b0; instr_ready = 1'b0; redir_valid = 1'b0;
      redir_target = '0; halt = 1'b0; ack_delay = 0; ack_force = 1'b0;
      tick(); tick();
      check_idle_outputs("reset");
      rst_n = 1'b1;
      tick();

      // Table-driven fetch/accept loop
      for (int i = 0; i < 6; i++) begin
         ack_delay = vecs[i].delay;
         wait_req(c);
         if (i > 0) check($sformatf("v%0d_accept_to_req", i), c, 0);
         check($sformatf("v%0d_addr", i), imem_addr, vecs[i].exp_addr);
         exp_q.push_back(vecs[i].exp_instr);
         wait_valid(c);
         check($sformatf("v%0d_ack_to_valid", i), c, vecs[i].delay + 1);
         for (int k = 0; k < vecs[i].ready_wait; k++) begin
            tick();
            check($sformatf("v%0d_hold_valid%0d", i, k), instr_valid, 1'b1);
            check($sformatf("v%0d_hold_instr%0d", i, k), instr, vecs[i].exp_instr);
            check($sformatf("v%0d_hold_noinc%0d", i, k), PCinc, 1'b0);
         end
         accept($sformatf("v%0d", i));
         tick();
      end

      // Redirect during HOLD, squashed even with ready=1
      ack_delay = 0;
      wait_req(c);
      check("rh_addr", imem_addr, 32'd6);
      wait_valid(c);
      redir_valid = 1'b1; redir_target = 32'h40; instr_ready = 1'b1;
      tick();
      redir_valid = 1'b0; instr_ready = 1'b0;
      check("rh_valid_drop", instr_valid, 1'b0);
      check("rh_pcload", PCload, 1'b1);
      check("rh_pcdata", PCdata, 32'h40);
      check("rh_no_pcinc", PCinc, 1'b0);
      tick();
      check("rh_next_addr", imem_addr, 32'h40);
      exp_q.push_back(32'h140);
      wait_valid(c);
      accept("rh_after");
      tick();

      // Redirect during FETCH with a 3-cycle ack delay
      ack_delay = 3;
      wait_req(c);
      check("rf_addr", imem_addr, 32'h41);
      tick();
      redir_valid = 1'b1; redir_target = 32'h80;
      tick();
      redir_valid = 1'b0;
      c = 0;
      while (!PCload && c < 20) begin
         check("rf_no_valid", instr_valid, 1'b0);
         tick(); c++;
      end
      check("rf_pcload", PCload, 1'b1);
      check("rf_pcdata", PCdata, 32'h80);
      ack_delay = 0;
      tick();
      check("rf_next_addr", imem_addr, 32'h80);
      exp_q.push_back(32'h180);
      wait_valid(c);
      accept("rf_after");
      tick();

      // Halt during HOLD: instruction completes, then parked
      wait_req(c);
      check("hl_addr", imem_addr, 32'h81);
      exp_q.push_back(32'h181);
      wait_valid(c);
      halt = 1'b1;
      accept("hl");
      for (int k = 0; k < 4; k++) begin
         if (k == 1) begin redir_valid = 1'b1; redir_target = 32'h99; end
         tick();
         redir_valid = 1'b0;
         check($sformatf("hl_noreq%0d", k), imem_req, 1'b0);
         check($sformatf("hl_novalid%0d", k), instr_valid, 1'b0);
         check($sformatf("hl_nostrobe%0d", k), PCload | PCinc, 1'b0);
      end
      halt = 1'b0;
      tick();
      check("hl_resume_req", imem_req, 1'b1);
      check("hl_resume_addr", imem_addr, 32'h82);
      exp_q.push_back(32'h182);
      wait_valid(c);
      accept("hl_after");
      tick();

      // Reset with an outstanding fetch; late ack must be ignored
      ack_delay = 3;
      wait_req(c);
      check("rs_addr", imem_addr, 32'h83);
      tick();
      rst_n = 1'b0;
      tick();
      check_idle_outputs("rs");
      rst_n = 1'b1; ack_force = 1'b1; ack_delay = 0;
      tick();
      ack_force = 1'b0;
      check("rs_late_instr", instr, '0);
      check("rs_late_valid", instr_valid, 1'b0);
      check("rs_restart_req", imem_req, 1'b1);
      check("rs_restart_addr", imem_addr, 32'd0);
      exp_q.push_back(32'h100);
      wait_valid(c);
      accept("rs_after");
      tick();

      check("sb_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
